add_arbiter: RTL and testbench

ADD_ARBITER -- requirements
Module: add_arbiter

---
 rtl/add_arbiter.sv | 86 ++++++++
 tb/tb_add_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/add_arbiter.sv
// add_arbiter: round-robin arbiter for two requesters sharing one 32-bit add/sub datapath.
// Define ADD_ARBITER_SATURATE_EN to clamp overflowed results instead of wrapping.
module add_arbiter #(
   parameter int unsigned PRIO_INIT = 0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic        req0_sub,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   input  logic        req1_sub,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_overflow,
   output logic        rsp_id
);
   typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;
   state_t      state;
   logic        prio;
   logic [31:0] op_a, op_b;
   logic        op_sub, op_id;
   logic        gnt0, gnt1;
   logic [31:0] b_x, lo, res;
   logic        c31, cout, s31, ovf;
   always_comb begin
      gnt0 = req0_valid && (!req1_valid || !prio);
      gnt1 = req1_valid && (!req0_valid || prio);
      req0_ready = !reset && state == IDLE && gnt0;
      req1_ready = !reset && state == IDLE && gnt1;
      rsp_valid = !reset && state == HOLD;
   end
   // Low 31 bits and the sign bit are added separately to expose the carry into bit 31.
   always_comb begin
      b_x = op_b ^ {32{op_sub}};
      lo = {1'b0, op_a[30:0]} + {1'b0, b_x[30:0]} + {31'b0, op_sub};
      c31 = lo[31];
      {cout, s31} = {1'b0, op_a[31]} + {1'b0, b_x[31]} + {1'b0, c31};
      ovf = c31 ^ cout;
`ifdef ADD_ARBITER_SATURATE_EN
      res = ovf ? (op_a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF) : {s31, lo[30:0]};
`else
      res = {s31, lo[30:0]};
`endif
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         prio <= (PRIO_INIT != 0);
         rsp_data <= '0;
         rsp_overflow <= 1'b0;
         rsp_id <= 1'b0;
         op_a <= '0;
         op_b <= '0;
         op_sub <= 1'b0;
         op_id <= 1'b0;
      end else begin
         case (state)
            IDLE: if (gnt0 || gnt1) begin
               op_a <= gnt1 ? req1_a : req0_a;
               op_b <= gnt1 ? req1_b : req0_b;
               op_sub <= gnt1 ? req1_sub : req0_sub;
               op_id <= gnt1;
               state <= EXEC;
            end
            EXEC: begin
               rsp_data <= res;
               rsp_overflow <= ovf;
               rsp_id <= op_id;
               state <= HOLD;
            end
            HOLD: if (rsp_ready) begin
               prio <= !rsp_id;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_add_arbiter.sv
// tb_add_arbiter: directed scenarios plus randomized traffic checked against an arithmetic reference.
module tb_add_arbiter;
   localparam int unsigned PRIO_INIT = 0;
   localparam longint MAXV = 2147483647;
   localparam longint MINV = -MAXV - 1;
   logic        clock = 1'b0, reset = 1'b1;
   logic        req0_valid = 1'b0, req0_ready, req0_sub = 1'b0;
   logic [31:0] req0_a = '0, req0_b = '0;
   logic        req1_valid = 1'b0, req1_ready, req1_sub = 1'b0;
   logic [31:0] req1_a = '0, req1_b = '0;
   logic        rsp_valid, rsp_ready = 1'b0, rsp_overflow, rsp_id;
   logic [31:0] rsp_data;
   int total = 0, bad = 0;

   add_arbiter #(.PRIO_INIT(PRIO_INIT)) dut (
      .clock(clock), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_overflow(rsp_overflow), .rsp_id(rsp_id)
   );

   always #5 clock = ~clock;

   function automatic logic [32:0] ref_op(input logic [31:0] a, input logic [31:0] b, input logic sub);
      longint r;
      logic o;
      logic [31:0] d;
      r = sub ? longint'($signed(a)) - longint'($signed(b)) : longint'($signed(a)) + longint'($signed(b));
      o = (r > MAXV) || (r < MINV);
      d = r[31:0];
`ifdef ADD_ARBITER_SATURATE_EN
      if (o) d = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
      return {o, d};
   endfunction

   function automatic logic [31:0] rnd_op();
      case ($urandom_range(0, 5))
         0: return 32'h7FFF_FFFF;
         1: return 32'h8000_0000;
         2: return 32'h0;
         3: return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rsp_ready = 1'b0;
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clock);
      reset = 1'b1;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b%b want=00", req0_ready, req1_ready); end
      @(negedge clock);
      #1;
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
      total++; if (rsp_data !== 32'h0 || rsp_overflow !== 1'b0 || rsp_id !== 1'b0) begin bad++; $display("FAIL reset_rsp got=%h/%b/%b want=0/0/0", rsp_data, rsp_overflow, rsp_id); end
      reset = 1'b0;
      #1;
      total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++; $display("FAIL first_grant got=%b%b want=10", req0_ready, req1_ready); end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   task automatic test_ops();
      logic        ids [3] = '{1'b0, 1'b1, 1'b1};
      logic [31:0] as [3] = '{32'h7FFF_FFFF, 32'd5, 32'h8000_0000};
      logic [31:0] bs [3] = '{32'd1, 32'd7, 32'd1};
      logic        subs [3] = '{1'b0, 1'b1, 1'b1};
      logic        ovfs [3] = '{1'b1, 1'b0, 1'b1};
`ifdef ADD_ARBITER_SATURATE_EN
      logic [31:0] ds [3] = '{32'h7FFF_FFFF, 32'hFFFF_FFFE, 32'h8000_0000};
`else
      logic [31:0] ds [3] = '{32'h8000_0000, 32'hFFFF_FFFE, 32'h7FFF_FFFF};
`endif
      do_reset();
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         if (ids[k]) begin req1_valid = 1'b1; req1_a = as[k]; req1_b = bs[k]; req1_sub = subs[k]; end
         else begin req0_valid = 1'b1; req0_a = as[k]; req0_b = bs[k]; req0_sub = subs[k]; end
         #1;
         total++; if ((ids[k] ? req1_ready : req0_ready) !== 1'b1) begin bad++; $display("FAIL op%0d_ready got=0 want=1", k); end
         @(negedge clock);
         req0_valid = 1'b0;
         req1_valid = 1'b0;
         #1;
         total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL op%0d_early_valid got=%b want=0", k, rsp_valid); end
         @(negedge clock);
         #1;
         total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL op%0d_latency got=%b want=1", k, rsp_valid); end
         total++; if (rsp_data !== ds[k] || rsp_overflow !== ovfs[k] || rsp_id !== ids[k]) begin bad++; $display("FAIL op%0d_result got=%h/%b/%b want=%h/%b/%b", k, rsp_data, rsp_overflow, rsp_id, ds[k], ovfs[k], ids[k]); end
         rsp_ready = 1'b1;
         @(negedge clock);
         rsp_ready = 1'b0;
         #1;
         total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL op%0d_after_hs got=%b want=0", k, rsp_valid); end
      end
   endtask

   task automatic test_back_to_back();
      logic q [$];
      logic p0 = 1'b0, p1 = 1'b0;
      do_reset();
      @(negedge clock);
      req0_valid = 1'b1; req0_a = $urandom; req0_b = $urandom; req0_sub = 1'b0;
      req1_valid = 1'b1; req1_a = $urandom; req1_b = $urandom; req1_sub = 1'b1;
      rsp_ready = 1'b1;
      for (int c = 0; c < 15; c++) begin
         #1;
         if (rsp_valid && rsp_ready) q.push_back(rsp_id);
         total++; if ((req0_ready && p0) || (req1_ready && p1) || (req0_ready && req1_ready)) begin bad++; $display("FAIL b2b_pulse cyc=%0d got=%b%b prev=%b%b want=single", c, req0_ready, req1_ready, p0, p1); end
         p0 = req0_ready;
         p1 = req1_ready;
         @(negedge clock);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      total++; if (q.size() < 4) begin bad++; $display("FAIL b2b_count got=%0d want>=4", q.size()); end
      else if (q[0] !== 1'b0 || q[1] !== 1'b1 || q[2] !== 1'b0 || q[3] !== 1'b1) begin bad++; $display("FAIL b2b_order got=%b%b%b%b want=0101", q[0], q[1], q[2], q[3]); end
   endtask

   task automatic test_hold();
      do_reset();
      @(negedge clock);
      req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd4; req0_sub = 1'b0;
      #1;
      total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL hold_accept got=%b want=1", req0_ready); end
      @(negedge clock);
      #1;
      total++; if (req0_ready !== 1'b0) begin bad++; $display("FAIL hold_exec_ready got=%b want=0", req0_ready); end
      for (int c = 0; c < 5; c++) begin
         @(negedge clock);
         #1;
         total++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd7 || rsp_overflow !== 1'b0 || rsp_id !== 1'b0 || req0_ready !== 1'b0) begin bad++; $display("FAIL hold_stable cyc=%0d got=%b/%h/%b/%b/rdy%b want=1/00000007/0/0/rdy0", c, rsp_valid, rsp_data, rsp_overflow, rsp_id, req0_ready); end
      end
      rsp_ready = 1'b1;
      @(negedge clock);
      rsp_ready = 1'b0;
      #1;
      total++; if (req0_ready !== 1'b1 || rsp_valid !== 1'b0) begin bad++; $display("FAIL hold_regrant got=rdy%b/vld%b want=rdy1/vld0", req0_ready, rsp_valid); end
      req0_valid = 1'b0;
   endtask

   task automatic test_reset_exec();
      do_reset();
      @(negedge clock);
      req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_sub = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clock);
      req0_valid = 1'b0;
      @(negedge clock);
      @(negedge clock);
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin bad++; $display("FAIL rr_after_hs got=%b%b want=01", req0_ready, req1_ready); end
      @(negedge clock);
      reset = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #1;
         total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_exec_discard cyc=%0d got=%b want=0", c, rsp_valid); end
         @(negedge clock);
      end
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      total++; if (req0_ready !== (PRIO_INIT == 0) || req1_ready !== (PRIO_INIT != 0)) begin bad++; $display("FAIL rst_exec_prio got=%b%b want=prio%0d", req0_ready, req1_ready, PRIO_INIT); end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rsp_ready = 1'b0;
   endtask

   task automatic test_random();
      logic busy = 1'b0, mprio = (PRIO_INIT != 0), exp_id = 1'b0;
      logic e0, e1, ev;
      logic [32:0] exp_r = '0;
      int acc = 0;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         @(negedge clock);
         req0_valid = ($urandom_range(0, 2) != 0); req0_a = rnd_op(); req0_b = rnd_op(); req0_sub = 1'($urandom);
         req1_valid = ($urandom_range(0, 2) != 0); req1_a = rnd_op(); req1_b = rnd_op(); req1_sub = 1'($urandom);
         rsp_ready = ($urandom_range(0, 2) != 0);
         #1;
         e0 = !busy && req0_valid && (!req1_valid || !mprio);
         e1 = !busy && req1_valid && (!req0_valid || mprio);
         ev = busy && (i >= acc + 2);
         total++; if (req0_ready !== e0 || req1_ready !== e1) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b%b want=%b%b", i, req0_ready, req1_ready, e0, e1); end
         total++; if (rsp_valid !== ev) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b want=%b", i, rsp_valid, ev); end
         if (ev) begin
            total++; if (rsp_data !== exp_r[31:0] || rsp_overflow !== exp_r[32] || rsp_id !== exp_id) begin bad++; $display("FAIL rnd_result cyc=%0d got=%h/%b/%b want=%h/%b/%b", i, rsp_data, rsp_overflow, rsp_id, exp_r[31:0], exp_r[32], exp_id); end
            if (rsp_ready) begin busy = 1'b0; mprio = !exp_id; end
         end
         if (e0 || e1) begin
            busy = 1'b1;
            acc = i;
            exp_id = e1;
            exp_r = e1 ? ref_op(req1_a, req1_b, req1_sub) : ref_op(req0_a, req0_b, req0_sub);
         end
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_ops();
      test_back_to_back();
      test_hold();
      test_reset_exec();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
